// File: rtl/ram_bank.sv
// ram_bank: register bank with clear, parallel load, addressed write, shift-in and one read port.
// Define RAM_BANK_RDREG_EN to register the read port (1-cycle latency); default is combinational.
module ram_bank #(
    parameter int unsigned BIT_SIZE = 16,
    parameter int unsigned RAM_SIZE = 8,
    localparam int unsigned ADDR_W = $clog2(RAM_SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                ld,
    input  logic [BIT_SIZE-1:0] par_in [RAM_SIZE],
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [BIT_SIZE-1:0] wr_data,
    input  logic                sh_en,
    input  logic [BIT_SIZE-1:0] sh_in,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [BIT_SIZE-1:0] rd_data,
    output logic                rd_valid,
    output logic [BIT_SIZE-1:0] par_out [RAM_SIZE],
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                empty
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [BIT_SIZE-1:0] mem_q [RAM_SIZE];
    logic [BIT_SIZE-1:0] mem_d [RAM_SIZE];
    logic [RAM_SIZE-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                wr_in_range, rd_in_range;
    logic [BIT_SIZE-1:0] rd_data_c;
    logic                rd_valid_c;

    assign wr_in_range = (32'(wr_addr) < RAM_SIZE);
    assign rd_in_range = (32'(rd_addr) < RAM_SIZE);

    // One operation per cycle; lower-priority requests are dropped, even when a
    // higher-priority write is itself ignored for being out of range.
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        if (clr) begin
            for (int i = 0; i < int'(RAM_SIZE); i++) begin
                mem_d[i] = '0;
            end
            valid_d = '0;
        end else if (ld) begin
            mem_d   = par_in;
            valid_d = '1;
        end else if (wr_en) begin
            if (wr_in_range) begin
                mem_d[wr_addr]   = wr_data;
                valid_d[wr_addr] = 1'b1;
            end
        end else if (sh_en) begin
            for (int i = int'(RAM_SIZE) - 1; i > 0; i--) begin
                mem_d[i]   = mem_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
            mem_d[0]   = sh_in;
            valid_d[0] = 1'b1;
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < int'(RAM_SIZE); i++) begin
            cnt_d = cnt_d + CNT_W'(valid_d[i]);
        end
        full_d  = (cnt_d == CNT_W'(RAM_SIZE));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(RAM_SIZE); i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            mem_q   <= mem_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign par_out = mem_q;
    assign count   = cnt_q;
    assign full    = full_q;
    assign empty   = empty_q;

    // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
    always_comb begin
        rd_data_c  = '0;
        rd_valid_c = 1'b0;
        if (rst && rd_in_range) begin
            rd_data_c  = mem_q[rd_addr];
            rd_valid_c = valid_q[rd_addr];
        end
    end

`ifdef RAM_BANK_RDREG_EN
    logic [BIT_SIZE-1:0] rd_data_q;
    logic                rd_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_c;
            rd_valid_q <= rd_valid_c;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`else
    assign rd_data  = rd_data_c;
    assign rd_valid = rd_valid_c;
`endif

endmodule

// File: tb/tb_ram_bank.sv
// Scoreboard bench for ram_bank: an 8-entry instance for the main behaviour and a
// 6-entry instance for out-of-range addressing.
module tb_ram_bank;

`ifdef RAM_BANK_RDREG_EN
    localparam int RD_LAT = 1;
`else
    localparam int RD_LAT = 0;
`endif

    localparam int S_PAR    = 0;
    localparam int S_CNT    = 1;
    localparam int S_FULL   = 2;
    localparam int S_EMPTY  = 3;
    localparam int S_RDATA  = 4;
    localparam int S_RVALID = 5;
    localparam int S_PAR_B  = 10;
    localparam int S_CNT_B  = 11;
    localparam int S_RDAT_B = 14;
    localparam int S_RVAL_B = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        clr, ld, wr_en, sh_en;
    logic [15:0] par_in [8];
    logic [2:0]  wr_addr, rd_addr;
    logic [15:0] wr_data, sh_in, rd_data;
    logic        rd_valid;
    logic [15:0] par_out [8];
    logic [3:0]  count;
    logic        full, empty;

    logic        clr_b, ld_b, wr_en_b, sh_en_b;
    logic [15:0] par_in_b [6];
    logic [2:0]  wr_addr_b, rd_addr_b;
    logic [15:0] wr_data_b, sh_in_b, rd_data_b;
    logic        rd_valid_b;
    logic [15:0] par_out_b [6];
    logic [3:0]  count_b;
    logic        full_b, empty_b;

    ram_bank #(.BIT_SIZE(16), .RAM_SIZE(8)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .par_in(par_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sh_en(sh_en), .sh_in(sh_in), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .par_out(par_out),
        .count(count), .full(full), .empty(empty)
    );

    ram_bank #(.BIT_SIZE(16), .RAM_SIZE(6)) u_dut_b (
        .clk(clk), .rst(rst), .clr(clr_b), .ld(ld_b), .par_in(par_in_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .sh_en(sh_en_b), .sh_in(sh_in_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .par_out(par_out_b),
        .count(count_b), .full(full_b), .empty(empty_b)
    );

    typedef struct {
        string       name;
        int          sel;
        int          idx;
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t        sb [$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] mon_act;
    logic [15:0] exp_mem [8];

    function automatic logic [31:0] observe(input int sel, input int idx);
        case (sel)
            S_PAR:    return 32'(par_out[idx]);
            S_CNT:    return 32'(count);
            S_FULL:   return 32'(full);
            S_EMPTY:  return 32'(empty);
            S_RDATA:  return 32'(rd_data);
            S_RVALID: return 32'(rd_valid);
            S_PAR_B:  return 32'(par_out_b[idx]);
            S_CNT_B:  return 32'(count_b);
            S_RDAT_B: return 32'(rd_data_b);
            S_RVAL_B: return 32'(rd_valid_b);
            default:  return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: every falling edge, compare all expectations due on this cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                mon_act = observe(sb[i].sel, sb[i].idx);
                n_total++;
                if (mon_act === sb[i].val) n_pass++;
                else $display("FAIL %s: got %0h, expected %0h", sb[i].name, mon_act, sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input string name, input int sel, input int idx,
                             input logic [31:0] val, input int lat);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.idx  = idx;
        e.val  = val;
        e.due  = cyc + 1 + lat;
        sb.push_back(e);
    endtask

    task automatic expect_mem(input string tag);
        for (int i = 0; i < 8; i++) begin
            expect_at($sformatf("%s par_out[%0d]", tag, i), S_PAR, i, 32'(exp_mem[i]), 0);
        end
    endtask

    task automatic expect_flags(input string tag, input int cnt, input int fl, input int em);
        expect_at({tag, " count"}, S_CNT, 0, 32'(cnt), 0);
        expect_at({tag, " full"}, S_FULL, 0, 32'(fl), 0);
        expect_at({tag, " empty"}, S_EMPTY, 0, 32'(em), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        {clr, ld, wr_en, sh_en} = '0;
        {clr_b, ld_b, wr_en_b, sh_en_b} = '0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; sh_in = '0;
        wr_addr_b = '0; rd_addr_b = '0; wr_data_b = '0; sh_in_b = '0;
        foreach (par_in[i]) par_in[i] = '0;
        foreach (par_in_b[i]) par_in_b[i] = '0;

        // Held in reset
        tick();
        foreach (exp_mem[i]) exp_mem[i] = '0;
        expect_mem("reset");
        expect_flags("reset", 0, 0, 1);
        expect_at("reset rd_data", S_RDATA, 0, 32'h0, 0);
        expect_at("reset rd_valid", S_RVALID, 0, 32'h0, 0);
        expect_at("reset count_b", S_CNT_B, 0, 32'h0, 0);
        tick();

        // Load on the first edge after reset release
        foreach (par_in[i]) par_in[i] = 16'h1000 + 16'(i);
        rst = 1'b1;
        ld = 1'b1;
        tick();
        ld = 1'b0;
        foreach (exp_mem[i]) exp_mem[i] = 16'h1000 + 16'(i);
        expect_mem("ld");
        expect_flags("ld", 8, 1, 0);
        rd_addr = 3'd5;
        expect_at("ld rd_data[5]", S_RDATA, 0, 32'h1005, RD_LAT);
        expect_at("ld rd_valid[5]", S_RVALID, 0, 32'h1, RD_LAT);
        tick(); tick();

        // Reset asserted mid-ld, between edges
        foreach (par_in[i]) par_in[i] = 16'h3000 + 16'(i);
        ld = 1'b1;
        #2;
        rst = 1'b0;
        foreach (exp_mem[i]) exp_mem[i] = '0;
        expect_mem("midld_rst");
        expect_flags("midld_rst", 0, 0, 1);
        expect_at("midld_rst rd_data", S_RDATA, 0, 32'h0, 0);
        expect_at("midld_rst rd_valid", S_RVALID, 0, 32'h0, 0);
        tick();
        ld = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Single writes, including a rewrite of a valid entry
        clr = 1'b1;
        tick();
        clr = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        tick();
        expect_at("wr1 count", S_CNT, 0, 32'd1, 0);
        wr_data = 16'hCAFE;
        tick();
        expect_at("rewrite count", S_CNT, 0, 32'd1, 0);
        wr_addr = 3'd7; wr_data = 16'h0001;
        tick();
        wr_en = 1'b0;
        foreach (exp_mem[i]) exp_mem[i] = '0;
        exp_mem[3] = 16'hCAFE;
        exp_mem[7] = 16'h0001;
        expect_mem("wr");
        expect_flags("wr", 2, 0, 0);
        rd_addr = 3'd0;
        expect_at("wr rd_data[0]", S_RDATA, 0, 32'h0, RD_LAT);
        expect_at("wr rd_valid[0]", S_RVALID, 0, 32'h0, RD_LAT);
        tick(); tick();
        rd_addr = 3'd3;
        expect_at("wr rd_data[3]", S_RDATA, 0, 32'hCAFE, RD_LAT);
        expect_at("wr rd_valid[3]", S_RVALID, 0, 32'h1, RD_LAT);
        tick(); tick();

        // Nine shifts: the ninth runs while full
        clr = 1'b1;
        tick();
        clr = 1'b0;
        sh_en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            sh_in = 16'(k);
            tick();
            expect_at($sformatf("shift%0d count", k), S_CNT, 0, 32'((k > 8) ? 8 : k), 0);
        end
        sh_en = 1'b0;
        foreach (exp_mem[i]) exp_mem[i] = 16'(9 - i);
        expect_mem("shift");
        expect_at("shift full", S_FULL, 0, 32'h1, 0);
        expect_at("shift empty", S_EMPTY, 0, 32'h0, 0);
        tick();

        // Priority: ld beats wr and sh
        foreach (par_in[i]) par_in[i] = 16'h5000 + 16'(i);
        ld = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        sh_en = 1'b1; sh_in = 16'h7777;
        tick();
        ld = 1'b0; wr_en = 1'b0; sh_en = 1'b0;
        foreach (exp_mem[i]) exp_mem[i] = 16'h5000 + 16'(i);
        expect_mem("prio_ld");
        expect_flags("prio_ld", 8, 1, 0);
        tick();

        // Priority: clr beats ld
        clr = 1'b1; ld = 1'b1;
        tick();
        clr = 1'b0; ld = 1'b0;
        foreach (exp_mem[i]) exp_mem[i] = '0;
        expect_mem("prio_clr");
        expect_flags("prio_clr", 0, 0, 1);
        tick();

        // Priority: wr beats sh
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hAAAA;
        sh_en = 1'b1; sh_in = 16'h5555;
        tick();
        wr_en = 1'b0; sh_en = 1'b0;
        exp_mem[2] = 16'hAAAA;
        expect_mem("prio_wr");
        expect_at("prio_wr count", S_CNT, 0, 32'd1, 0);
        tick();

        // Read of the address being written returns the old value
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hBBBB; rd_addr = 3'd2;
        expect_at("rd_during_wr rd_data", S_RDATA, 0, 32'hAAAA, RD_LAT);
        tick();
        wr_en = 1'b0;
        expect_at("rd_during_wr par_out[2]", S_PAR, 2, 32'hBBBB, 0);
        tick(); tick();

        // 6-entry bank: out-of-range writes and reads
        wr_en_b = 1'b1; wr_addr_b = 3'd2; wr_data_b = 16'h1234;
        tick();
        expect_at("b wr count", S_CNT_B, 0, 32'd1, 0);
        wr_addr_b = 3'd6; wr_data_b = 16'hDEAD;
        tick();
        wr_addr_b = 3'd7;
        tick();
        wr_en_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_at($sformatf("b oor par_out[%0d]", i), S_PAR_B, i,
                      (i == 2) ? 32'h1234 : 32'h0, 0);
        end
        expect_at("b oor count", S_CNT_B, 0, 32'd1, 0);
        rd_addr_b = 3'd6;
        expect_at("b rd6 rd_data", S_RDAT_B, 0, 32'h0, RD_LAT);
        expect_at("b rd6 rd_valid", S_RVAL_B, 0, 32'h0, RD_LAT);
        tick(); tick();
        rd_addr_b = 3'd7;
        expect_at("b rd7 rd_data", S_RDAT_B, 0, 32'h0, RD_LAT);
        expect_at("b rd7 rd_valid", S_RVAL_B, 0, 32'h0, RD_LAT);
        tick(); tick();
        rd_addr_b = 3'd2;
        expect_at("b rd2 rd_data", S_RDAT_B, 0, 32'h1234, RD_LAT);
        expect_at("b rd2 rd_valid", S_RVAL_B, 0, 32'h1, RD_LAT);
        tick(); tick();

        for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
        if (sb.size() != 0) begin
            foreach (sb[i]) $display("FAIL %s: never checked, expected %0h", sb[i].name, sb[i].val);
            n_total += sb.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
